cam_ctrl: RTL and testbench

- Control stage for a CAM array built from DEPTH rows of WIDTH-bit storage.
- Upstream of the rows: accepts write and search requests over valid/ready handshakes, picks the victim row for writes, and drives per-row write enables plus a broadcast compare key.
- Downstream of the rows: collects per-row match and valid lines, priority-encodes them, and returns a registered hit/index response.

---
 rtl/cam_pkg.sv | 12 +
 rtl/cam_prio_enc.sv | 23 ++
 rtl/cam_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cam_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types for the CAM control stage.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    CMP   = 3'd2,
    EVAL  = 3'd3,
    RESP  = 3'd4
  } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module cam_prio_enc #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// CAM control stage: write victim selection, search sequencing and hit/index response.
// Build option CAM_DUP_CHECK_EN routes writes through a compare so duplicates overwrite in place.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             srch_valid_i,
  output logic             srch_ready_o,
  input  logic [WIDTH-1:0] srch_key_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic [IDX_W-1:0] rsp_idx_o,
  output logic [WIDTH-1:0] row_data_o,
  output logic [DEPTH-1:0] row_we_o,
  output logic             row_cmp_en_o,
  output logic [WIDTH-1:0] row_cmp_o,
  input  logic [DEPTH-1:0] row_match_i,
  input  logic [DEPTH-1:0] row_valid_i,
  output logic             full_o
);

  cam_state_e       state;
  logic [IDX_W-1:0] rr_ptr;

  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] qual_vec;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_found;
  logic [IDX_W-1:0] victim;
  logic             replace_valid;

`ifdef CAM_DUP_CHECK_EN
  logic             op_wr;
`endif

  assign free_vec = ~row_valid_i;
  assign qual_vec = row_match_i & row_valid_i;
  assign full_o   = &row_valid_i;

  assign wr_ready_o   = (state == IDLE);
  assign srch_ready_o = (state == IDLE) && !wr_valid_i;

  cam_prio_enc #(.DEPTH(DEPTH)) u_free_enc (
    .vec   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  cam_prio_enc #(.DEPTH(DEPTH)) u_hit_enc (
    .vec   (qual_vec),
    .idx   (hit_idx),
    .found (hit_found)
  );

  // Prefer an empty row; once full, replace round-robin.
  always_comb begin
    victim        = rr_ptr;
    replace_valid = 1'b1;
    if (free_found) begin
      victim        = free_idx;
      replace_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_hit_o    <= 1'b0;
      rsp_idx_o    <= '0;
      row_data_o   <= '0;
      row_we_o     <= '0;
      row_cmp_en_o <= 1'b0;
      row_cmp_o    <= '0;
`ifdef CAM_DUP_CHECK_EN
      op_wr        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wr_valid_i) begin
            row_data_o <= wr_data_i;
`ifdef CAM_DUP_CHECK_EN
            row_cmp_o    <= wr_data_i;
            row_cmp_en_o <= 1'b1;
            op_wr        <= 1'b1;
            state        <= CMP;
`else
            row_we_o <= DEPTH'(1) << victim;
            if (replace_valid) begin
              rr_ptr <= rr_ptr + IDX_W'(1);
            end
            state <= WRITE;
`endif
          end else if (srch_valid_i) begin
            row_cmp_o    <= srch_key_i;
            row_cmp_en_o <= 1'b1;
`ifdef CAM_DUP_CHECK_EN
            op_wr        <= 1'b0;
`endif
            state        <= CMP;
          end
        end

        WRITE: begin
          row_we_o <= '0;
          state    <= IDLE;
        end

        CMP: begin
          state <= EVAL;
        end

        EVAL: begin
          row_cmp_en_o <= 1'b0;
`ifdef CAM_DUP_CHECK_EN
          if (op_wr) begin
            // An existing copy is overwritten in place and does not advance the pointer.
            if (hit_found) begin
              row_we_o <= DEPTH'(1) << hit_idx;
            end else begin
              row_we_o <= DEPTH'(1) << victim;
              if (replace_valid) begin
                rr_ptr <= rr_ptr + IDX_W'(1);
              end
            end
            state <= WRITE;
          end else begin
            rsp_hit_o   <= hit_found;
            rsp_idx_o   <= hit_idx;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
`else
          rsp_hit_o   <= hit_found;
          rsp_idx_o   <= hit_idx;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
`endif
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural row array model.
// Expected write latency follows the CAM_DUP_CHECK_EN build option.
module tb_cam_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = 3;
`ifdef CAM_DUP_CHECK_EN
  localparam int WR_LAT = 3;
`else
  localparam int WR_LAT = 1;
`endif

  logic             clk;
  logic             reset;
  logic             wr_valid;
  logic             wr_ready_o;
  logic [WIDTH-1:0] wr_data;
  logic             srch_valid;
  logic             srch_ready_o;
  logic [WIDTH-1:0] srch_key;
  logic             rsp_valid_o;
  logic             rsp_ready;
  logic             rsp_hit_o;
  logic [IDX_W-1:0] rsp_idx_o;
  logic [WIDTH-1:0] row_data_o;
  logic [DEPTH-1:0] row_we_o;
  logic             row_cmp_en_o;
  logic [WIDTH-1:0] row_cmp_o;
  logic [DEPTH-1:0] row_match;
  logic [DEPTH-1:0] row_valid;
  logic             full_o;

  logic             tb_clear;
  logic [WIDTH-1:0] mdata [DEPTH];

  int checks;
  int failures;

  cam_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready_o),
    .wr_data_i    (wr_data),
    .srch_valid_i (srch_valid),
    .srch_ready_o (srch_ready_o),
    .srch_key_i   (srch_key),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_hit_o    (rsp_hit_o),
    .rsp_idx_o    (rsp_idx_o),
    .row_data_o   (row_data_o),
    .row_we_o     (row_we_o),
    .row_cmp_en_o (row_cmp_en_o),
    .row_cmp_o    (row_cmp_o),
    .row_match_i  (row_match),
    .row_valid_i  (row_valid),
    .full_o       (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row array model: contents clear to zero, so key 0 matches every empty row.
  always @(posedge clk) begin
    if (tb_clear) begin
      row_valid <= '0;
      for (int i = 0; i < DEPTH; i++) mdata[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (row_we_o[i]) begin
          mdata[i]     <= row_data_o;
          row_valid[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    row_match = '0;
    for (int i = 0; i < DEPTH; i++) row_match[i] = row_cmp_en_o && (mdata[i] == row_cmp_o);
  end

  task automatic reset_dut(input logic clr);
    @(negedge clk);
    reset = 1'b1;
    tb_clear = clr;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tb_clear = 1'b0;
  endtask

  task automatic do_write(input logic [WIDTH-1:0] d, input logic [DEPTH-1:0] exp_we);
    int n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    #1;
    checks++;
    if (wr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL wr_ready data=%0h: got %0b expected 1", d, wr_ready_o);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (row_we_o === '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != WR_LAT) begin
      failures++;
      $display("FAIL wr_latency data=%0h: got %0d expected %0d", d, n, WR_LAT);
    end
    checks++;
    if (row_we_o !== exp_we) begin
      failures++;
      $display("FAIL row_we data=%0h: got %0h expected %0h", d, row_we_o, exp_we);
    end
    checks++;
    if (row_data_o !== d) begin
      failures++;
      $display("FAIL row_data: got %0h expected %0h", row_data_o, d);
    end
  endtask

  task automatic do_search(input logic [WIDTH-1:0] key, input logic exp_hit,
                           input logic [IDX_W-1:0] exp_idx, input int hold);
    int n;
    @(negedge clk);
    srch_valid = 1'b1;
    srch_key   = key;
    #1;
    checks++;
    if (srch_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL srch_ready key=%0h: got %0b expected 1", key, srch_ready_o);
    end
    @(posedge clk);
    #1;
    srch_valid = 1'b0;
    n = 1;
    @(negedge clk);
    checks++;
    if (row_cmp_en_o !== 1'b1 || row_cmp_o !== key) begin
      failures++;
      $display("FAIL cmp_bus key=%0h: got en=%0b cmp=%0h expected en=1 cmp=%0h",
               key, row_cmp_en_o, row_cmp_o, key);
    end
    while (rsp_valid_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL rsp_latency key=%0h: got %0d expected 3", key, n);
    end
    checks++;
    if (rsp_hit_o !== exp_hit || rsp_idx_o !== exp_idx) begin
      failures++;
      $display("FAIL rsp key=%0h: got hit=%0b idx=%0d expected hit=%0b idx=%0d",
               key, rsp_hit_o, rsp_idx_o, exp_hit, exp_idx);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_hit_o !== exp_hit || rsp_idx_o !== exp_idx) begin
        failures++;
        $display("FAIL rsp_hold cycle=%0d: got v=%0b hit=%0b idx=%0d expected v=1 hit=%0b idx=%0d",
                 i, rsp_valid_o, rsp_hit_o, rsp_idx_o, exp_hit, exp_idx);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rsp_drop key=%0h: got %0b expected 0", key, rsp_valid_o);
    end
  endtask

  task automatic test_reset();
    reset_dut(1'b1);
    @(negedge clk);
    checks++;
    if (wr_ready_o !== 1'b1 || srch_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got wr=%0b srch=%0b expected 1 1", wr_ready_o, srch_ready_o);
    end
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_hit_o !== 1'b0 || rsp_idx_o !== '0 || row_we_o !== '0 ||
        row_cmp_en_o !== 1'b0 || row_data_o !== '0 || row_cmp_o !== '0 || full_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b hit=%0b idx=%0d we=%0h en=%0b data=%0h cmp=%0h full=%0b expected all 0",
               rsp_valid_o, rsp_hit_o, rsp_idx_o, row_we_o, row_cmp_en_o, row_data_o, row_cmp_o, full_o);
    end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = WIDTH'((i + 1) * 32'h11);
      do_write(d, DEPTH'(1) << i);
    end
    @(negedge clk);
    checks++;
    if (full_o !== 1'b1) begin
      failures++;
      $display("FAIL full_after_fill: got %0b expected 1", full_o);
    end
  endtask

  task automatic test_search();
    do_search(32'h33, 1'b1, 3'd2, 0);
    do_search(32'h99, 1'b0, 3'd0, 0);
    do_search(32'h88, 1'b1, 3'd7, 1);
  endtask

  // Round-robin replacement: rows 0,1,2 then nine more wrapping 7 -> 0 and ending at 3.
  task automatic test_replace();
    do_write(32'hA0, 8'h01);
    do_write(32'hA1, 8'h02);
    do_write(32'hA2, 8'h04);
    for (int i = 0; i < 9; i++) begin
      do_write(WIDTH'(32'hB0 + i), DEPTH'(1) << ((i + 3) % DEPTH));
    end
    do_search(32'hB8, 1'b1, 3'd3, 0);
    do_search(32'hA1, 1'b0, 3'd0, 0);
  endtask

  // Both requests together: the write wins, the search waits and then holds its response.
  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    wr_valid   = 1'b1;
    wr_data    = 32'hC5;
    srch_valid = 1'b1;
    srch_key   = 32'hC5;
    #1;
    checks++;
    if (wr_ready_o !== 1'b1 || srch_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL conflict_ready: got wr=%0b srch=%0b expected 1 0", wr_ready_o, srch_ready_o);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (row_we_o === '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (row_we_o !== 8'h10 || n != WR_LAT) begin
      failures++;
      $display("FAIL conflict_write: got we=%0h lat=%0d expected we=10 lat=%0d", row_we_o, n, WR_LAT);
    end
    checks++;
    if (srch_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL srch_ready_in_write: got %0b expected 0", srch_ready_o);
    end
    do_search(32'hC5, 1'b1, 3'd4, 5);
  endtask

  task automatic test_reset_midop();
    int seen;
    reset_dut(1'b1);
    do_search(32'h0, 1'b0, 3'd0, 0);
    do_write(32'h77, 8'h01);
    @(negedge clk);
    srch_valid = 1'b1;
    srch_key   = 32'h77;
    @(posedge clk);
    #1;
    srch_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || row_cmp_en_o !== 1'b0 ||
        row_cmp_o !== '0 || row_data_o !== '0 || rsp_hit_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_eval: got rdy=%0b v=%0b en=%0b cmp=%0h data=%0h hit=%0b expected 1 0 0 0 0 0",
               wr_ready_o, rsp_valid_o, row_cmp_en_o, row_cmp_o, row_data_o, rsp_hit_o);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL dropped_rsp: got %0d valid cycles expected 0", seen);
    end
    do_search(32'h77, 1'b1, 3'd0, 0);
  endtask

  task automatic test_dup();
    reset_dut(1'b1);
    do_write(32'h55, 8'h01);
`ifdef CAM_DUP_CHECK_EN
    do_write(32'h55, 8'h01);
`else
    do_write(32'h55, 8'h02);
`endif
    @(negedge clk);
    checks++;
    if (full_o !== 1'b0) begin
      failures++;
      $display("FAIL dup_full: got %0b expected 0", full_o);
    end
    do_search(32'h55, 1'b1, 3'd0, 0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    tb_clear   = 1'b1;
    wr_valid   = 1'b0;
    wr_data    = '0;
    srch_valid = 1'b0;
    srch_key   = '0;
    rsp_ready  = 1'b0;
    test_reset();
    test_fill();
    test_search();
    test_replace();
    test_back_to_back();
    test_reset_midop();
    test_dup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
